// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock switch sequencer: gates the mux output off, waits for the
// target source, moves sel, lets the mux settle, then re-enables the gate.
module clk_switch_ctrl #(
  parameter int CLK_NUM    = 3,
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = $clog2(CLK_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  input  logic [CLK_NUM-1:0] clk_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               gate_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  // One shared counter serves all three timed phases, so size it for the longest.
  localparam int MAX_GS  = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_MAX = (TIMEOUT > MAX_GS) ? TIMEOUT : MAX_GS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PAD_W   = 2 ** SEL_W;

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   NUM_L       = (SEL_W + 1)'(CLK_NUM);

  logic [CLK_NUM-1:0] sync_q, ready_s_q;
  logic [PAD_W-1:0]   ready_pad;

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_bad;

  // clk_ready is asynchronous to clk; only the second synchronizer stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      ready_s_q <= '0;
    end else begin
      sync_q    <= clk_ready;
      ready_s_q <= sync_q;
    end
  end

  assign ready_pad = PAD_W'(ready_s_q);
  assign req_bad   = ({1'b0, req_sel} >= NUM_L);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    gate_en_d   = gate_en_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_INIT: begin
        if (ready_s_q[0]) begin
          gate_en_d   = 1'b1;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          tgt_d = req_sel;
          if (req_bad) begin
            err_d = 1'b1;
          end else if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            gate_en_d   = 1'b0;
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
            cnt_d       = '0;
            state_d     = S_GATE;
          end
        end
      end
      S_GATE: begin
        if (cnt_q == GATE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        // A ready target wins over a timeout landing on the same cycle.
        if (ready_pad[tgt_q]) begin
          sel_d   = tgt_q;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          gate_en_d   = 1'b1;
          err_d       = 1'b1;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          gate_en_d   = 1'b1;
          done_d      = 1'b1;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gate_en_d   = 1'b0;
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        cnt_d       = '0;
        state_d     = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      sel_q       <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      gate_en_q   <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      gate_en_q   <= gate_en_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign gate_en   = gate_en_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed and randomized switch requests checked
// cycle by cycle against an edge-arithmetic timeline of each request.
module tb_clk_switch_ctrl;
  localparam int CLK_NUM    = 3;
  localparam int GATE_CYC   = 4;
  localparam int SETTLE_CYC = 4;
  localparam int TIMEOUT    = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic [2:0] clk_ready;
  logic [1:0] sel;
  logic       gate_en, busy, done, err;

  int total = 0;
  int bad   = 0;
  int exp_sel = 0;

  clk_switch_ctrl #(
    .CLK_NUM(CLK_NUM), .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .clk_ready(clk_ready), .sel(sel), .gate_en(gate_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // After rst_n release (mid-cycle) with source 0 ready: gate opens on the 3rd edge.
  task automatic init_after_release(input string nm);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (gate_en !== (e >= 3) || req_ready !== (e >= 3) || busy !== (e < 3) || sel !== 2'd0) begin
        bad++;
        $display("FAIL %s edge%0d: gate_en=%b req_ready=%b busy=%b sel=%0d want gate_en=%b sel=0",
                 nm, e, gate_en, req_ready, busy, sel, (e >= 3));
      end
    end
    exp_sel = 0;
  endtask

  // Issue one request and check every cycle until one past completion.
  // mode 0: target already ready; 1: target ready raised after edge E0+d; 2: never ready.
  task automatic run_req(input int tgt, input int mode, input int d, input bit noise, input string nm);
    int old, s_edge, r_edge, end_t, kind;
    bit to;
    logic [2:0] m;
    logic [1:0] e_sel;
    bit e_gate, e_busy, e_rdy, e_done, e_err;
    old = exp_sel;
    m = 3'b001 << tgt;
    clk_ready = (tgt < CLK_NUM && mode != 0) ? ~m : 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 2'(tgt);
    @(posedge clk);
    #1 req_valid = 1'b0;
    // kind 0: invalid, 1: already selected, 2: real switch
    kind   = (tgt >= CLK_NUM) ? 0 : (tgt == old) ? 1 : 2;
    r_edge = (mode == 0) ? 0 : (mode == 1) ? d + 3 : 1 << 30;
    s_edge = (r_edge > GATE_CYC + 1) ? r_edge : GATE_CYC + 1;
    to     = (kind == 2) && (s_edge > GATE_CYC + TIMEOUT);
    end_t  = (kind != 2) ? 0 : to ? GATE_CYC + TIMEOUT : s_edge + SETTLE_CYC;
    for (int t = 0; t <= end_t + 1; t++) begin
      @(negedge clk);
      e_gate = (t >= end_t);
      e_busy = (t < end_t);
      e_rdy  = (t >= end_t);
      e_done = (t == end_t) && (kind == 1 || (kind == 2 && !to));
      e_err  = (t == end_t) && (kind == 0 || to);
      e_sel  = (kind == 2 && !to && t >= s_edge) ? 2'(tgt) : 2'(old);
      total++;
      if (gate_en !== e_gate || busy !== e_busy || req_ready !== e_rdy ||
          done !== e_done || err !== e_err || sel !== e_sel) begin
        bad++;
        $display("FAIL %s t=%0d: got sel=%0d gate=%b busy=%b rdy=%b done=%b err=%b want sel=%0d gate=%b busy=%b rdy=%b done=%b err=%b",
                 nm, t, sel, gate_en, busy, req_ready, done, err, e_sel, e_gate, e_busy, e_rdy, e_done, e_err);
      end
      if (mode == 1 && t == d && tgt < CLK_NUM) clk_ready[tgt] = 1'b1;
      if (noise) begin
        if (t < end_t - 1) begin
          req_valid = 1'($urandom_range(0, 1));
          req_sel   = 2'($urandom_range(0, 3));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    if (kind == 2 && !to) exp_sel = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; clk_ready = 3'b001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sel !== 2'd0 || gate_en !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: sel=%0d gate_en=%b busy=%b req_ready=%b done=%b err=%b want 0,0,1,0,0,0",
               sel, gate_en, busy, req_ready, done, err);
    end
    rst_n = 1'b1;
    init_after_release("reset_init");
  endtask

  task automatic test_switch();
    run_req(2, 0, 0, 1'b0, "switch_0_to_2");
  endtask

  task automatic test_invalid();
    run_req(3, 0, 0, 1'b0, "invalid_sel3");
    run_req(2, 0, 0, 1'b0, "same_sel");
    run_req(0, 0, 0, 1'b0, "switch_back_0");
  endtask

  task automatic test_timeout();
    run_req(1, 2, 0, 1'b0, "timeout_to_1");
  endtask

  task automatic test_late_ready();
    run_req(1, 1, 20, 1'b1, "late_ready_noise");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_async_reset();
    int tgt;
    tgt = (exp_sel + 1) % CLK_NUM;
    clk_ready = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_sel = 2'(tgt);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (7) @(negedge clk);  // t=6: inside the settle window
    total++;
    if (sel !== 2'(tgt) || gate_en !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_settle: sel=%0d gate_en=%b want sel=%0d gate_en=0", sel, gate_en, tgt);
    end
    #2 rst_n = 1'b0;
    clk_ready = 3'b001;
    #1;
    total++;
    if (sel !== 2'd0 || gate_en !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: sel=%0d gate_en=%b busy=%b req_ready=%b want 0,0,1,0",
               sel, gate_en, busy, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_after_release("reinit");
    run_req(2, 0, 0, 1'b0, "post_reset_switch");
  endtask

  initial begin
    test_reset();
    test_switch();
    test_invalid();
    test_timeout();
    test_late_ready();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencing controller that drives the select input of the clock-switch mux cell and the enable of the downstream clock gate on its output. It accepts a requested clock index over a valid/ready handshake and gates the output off. It then waits for the target source to report stable, changes `sel`, lets the mux settle and re-enables the gate, so the mux never switches while its output is live. It runs on an always-on reference clock, separate from the clocks being switched.

## Interface
Parameters:
- CLK_NUM, 3, number of mux inputs (>= 2); SEL_W = ceil(log2(CLK_NUM))
- GATE_CYC, 4, cycles held in GATE_OFF before switching (>= 1)
- SETTLE_CYC, 4, cycles held after the `sel` change before re-enable (>= 1)
- TIMEOUT, 255, max cycles waiting for the target source ready (>= 1); counter width ceil(log2(TIMEOUT+1))

Ports:
- clk  input  1  always-on reference clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  switch request valid
- req_sel  input  SEL_W  requested clock index
- req_ready  output  1  controller can accept a request
- clk_ready  input  CLK_NUM  per-source stable flags, asynchronous to clk
- sel  output  SEL_W  mux select, registered
- gate_en  output  1  enable for the clock gate after the mux, registered
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a switch completes
- err  output  1  one-cycle pulse on invalid request or timeout

## Operation
- Each `clk_ready` bit passes through its own 2-flop synchronizer (ready_s). Only ready_s is used.
- States: INIT, IDLE, GATE_OFF, WAIT_SRC, SETTLE.
- Reset values: state=INIT, sel=0, gate_en=0, req_ready=0, busy=1, done=0, err=0, counters=0.
- INIT: when ready_s[0]=1, next edge sets gate_en=1 and moves to IDLE.
- IDLE: req_ready=1, busy=0. A request is accepted on an edge with req_valid & req_ready, and req_sel is latched into tgt.
  - tgt >= CLK_NUM: err pulses next cycle, no state change, sel and gate_en untouched.
  - tgt == sel: done pulses next cycle, no gating, remains IDLE.
  - Otherwise: gate_en<=0, cnt<=0, go to GATE_OFF.
- GATE_OFF: count GATE_CYC cycles, then go to WAIT_SRC with cnt cleared.
- WAIT_SRC:
  - ready_s[tgt]=1: sel<=tgt, cnt<=0, go to SETTLE.
  - ready_s[tgt] still 0 after TIMEOUT cycles: gate_en<=1 with the old sel, err pulse, go to IDLE.
- SETTLE: count SETTLE_CYC cycles, then gate_en<=1, done pulse, go to IDLE.
- Outside IDLE, req_valid is ignored and not queued. req_ready=0, so no handshake completes.
- Loss of the current source's ready while in IDLE is not monitored by this block.
- Reset asserted mid-operation forces all reset values immediately (asynchronous), including sel=0 and gate_en=0, and returns to INIT.

## Timing
- All outputs are registered. Nothing combinational passes from inputs to outputs.
- clk_ready to ready_s latency: 2 edges.
- Request accepted on edge E0 with valid target, target already ready, defaults:
  - gate_en falls at E0.
  - Enters WAIT_SRC at E4.
  - sel changes at E5.
  - gate_en rises and done is high at E9.
  - req_ready is high from E9.
- General: sel updates at E0+GATE_CYC+1+k, where k is the number of WAIT_SRC cycles with ready_s low. gate_en rises SETTLE_CYC edges later.
- Timeout: gate_en rises and err pulses at E0+GATE_CYC+TIMEOUT.
- gate_en is guaranteed low for at least GATE_CYC cycles before any sel change and for SETTLE_CYC cycles after it.
- done and err are each exactly one cycle wide and never high together.

## Test plan
- Reset with clk_ready=3'b001 held -> sel=0 and gate_en=0 during reset; gate_en=1 at the 3rd edge after rst_n rises; req_ready=1 from then on.
- IDLE with sel=0, all sources ready, request req_sel=2 -> gate_en=0 at E0, sel=2 at E5, gate_en=1 and done=1 at E9, busy high E0..E8.
- Request req_sel=3 with CLK_NUM=3 -> err=1 for one cycle, sel and gate_en unchanged, req_ready stays 1.
- Request req_sel=1 with clk_ready[1]=0 held -> gate_en low for GATE_CYC+TIMEOUT cycles, then gate_en=1 with sel=0 and err=1.
- Request to index 1 with clk_ready[1] raised 20 cycles after accept -> sel=1 at E0+20+2+1; gate_en rises 4 edges later; extra req_valid pulses meanwhile are ignored.
- Assert rst_n low during SETTLE -> sel=0, gate_en=0 immediately without waiting for a clock edge; after release, INIT behaviour repeats.
